cost_table_arbiter: RTL and testbench
=====================================

Name: cost_table_arbiter

Overview:
- Shares the single external worker/job cost table (address W/J, combinational 7-bit Cost return) between two permutation evaluators (requesters 0 and 1) so that two candidate assignments can be scored in an interleaved fashion.
- Uses round-robin arbitration with an optional bounded lock, so an evaluator can stream the 8 lookups of one permutation back-to-back.
- Accepts one lookup per cycle; responses are tagged back to the issuing requester with fixed latency.

Parameters:
- IDX_W, 3, width of worker and job indices.
- COST_W, 7, width of Cost.
- MAX_LOCK, 8, maximum consecutive locked grants while the other requester waits (1..15).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- req0, req1  input  1  lookup request from requester 0 / 1.
- lock0, lock1  input  1  request to keep the grant on the next cycle.
- w0, w1  input  IDX_W  worker index of the request.
- j0, j1  input  IDX_W  job index of the request.
- gnt0, gnt1  output  1  combinational grant; the request is accepted on the clock edge where req&gnt are both high.
- rsp_valid0, rsp_valid1  output  1  one-cycle pulse; the cost for an earlier accepted request is on rsp_cost.
- rsp_cost  output  COST_W  registered cost data, shared by both requesters.
- W  output  IDX_W  registered worker address to the cost table.
- J  output  IDX_W  registered job address to the cost table.
- Cost  input  COST_W  cost table data; combinational function of W/J, valid the cycle after W/J update.

Behaviour:
Reset (asynchronous, any time):
- W=0, J=0, rsp_cost=0, rsp_valid0/1=0.
- Round-robin pointer = 0 (requester 0 preferred).
- Lock owner = none, lock counter = 0, pending slot empty.
- An in-flight lookup is discarded and no rsp_valid is produced for it.

Grant (combinational, at most one of gnt0/gnt1 high; a grant is never given without the matching req):
- Lock active, owner requesting, and either counter < MAX_LOCK or the other requester idle: grant the owner.
- Otherwise, if only one requester is requesting, grant that one.
- Otherwise, if both are requesting, grant the requester the pointer selects.

On an accept edge (gnt_i & req_i):
- W<=w_i, J<=j_i; pending slot <= {valid, tag=i}.
- Pointer <= other requester.
- If lock_i=1: owner <= i and counter <= counter+1, or counter <= 1 if the owner changed.
- If lock_i=0: owner <= none and counter <= 0.

On an edge with no accept:
- W/J hold their values and the pending slot is cleared.
- Lock is released if the owner deasserts req or lock.
- Lock is held while the owner keeps req and lock high but loses the grant (at the MAX_LOCK limit).

Response path:
- The edge after an accept: rsp_cost<=Cost and rsp_valid_tag<=1 for exactly one cycle.
- Accept at edge N gives rsp_valid at edge N+1, i.e. data is available for one cycle after N+1.
- Back-to-back accepts give back-to-back responses in issue order; there is no stall and no backpressure.
- rsp_cost holds its last value when no response is produced.

Forced release at the MAX_LOCK limit:
- When counter reaches MAX_LOCK and the other requester is waiting, the other requester is granted next.
- The counter then restarts from 1 for the new owner if it locks.

Requester obligations:
- A requester holds w/j stable while req is high and ungranted.
- After an accept it may change w/j for its next request in the same cycle.
- Simultaneous first requests with no lock go to requester 0 after reset.
- lock without req is ignored.

Test Plan:
- Single lookup: req0=1, w0=2, j0=5 for one cycle after reset → gnt0=1 that cycle; W=2, J=5 at edge 1; with table Cost=37, rsp_valid0=1 and rsp_cost=37 after edge 2; rsp_valid1 stays 0.
- Round robin: req0=req1=1 held, locks 0, for 6 cycles → grants alternate 0,1,0,1,0,1; responses alternate with matching tags and costs, 1-edge lag.
- Locked burst: requester 0 locks for 8 lookups (w0=0..7) while req1 is held, MAX_LOCK=8 → eight consecutive gnt0, then gnt1 on cycle 9; W sequence 0..7 then w1.
- Lock limit with contention: MAX_LOCK=3, requester 0 locks continuously and req1 is held → pattern 0,0,0,1,0,0,0,1…; with req1 low, requester 0 is granted indefinitely.
- Reset mid-flight: assert RST for one half-cycle right after an accept edge → outputs go to reset values immediately; no rsp_valid for that lookup; after release, the first simultaneous request goes to requester 0.
- Idle hold: accept w1=6, j1=1, then all req low for 4 cycles → W=6, J=1 held; no further rsp_valid; rsp_cost retains the last value.

Source files
------------

// File: rtl/cost_table_arbiter.sv
// Round-robin arbiter with bounded lock that shares one cost table between
// two permutation evaluators; responses return one edge after acceptance.
module cost_table_arbiter #(
  parameter int IDX_W    = 3,
  parameter int COST_W   = 7,
  parameter int MAX_LOCK = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [IDX_W-1:0]  w0,
  input  logic [IDX_W-1:0]  w1,
  input  logic [IDX_W-1:0]  j0,
  input  logic [IDX_W-1:0]  j1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  output logic [COST_W-1:0] rsp_cost,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_LOCK);

  logic             ptr;
  logic             own_vld;
  logic             own_id;
  logic [CNT_W-1:0] cnt;
  logic             pend_vld;
  logic             pend_tag;

  logic             own_req;
  logic             own_lock;
  logic             oth_req;
  logic             hold;
  logic             acc;
  logic             acc_id;
  logic             acc_lock;
  logic [IDX_W-1:0] acc_w;
  logic [IDX_W-1:0] acc_j;

  always_comb begin
    own_req  = own_id ? req1 : req0;
    own_lock = own_id ? lock1 : lock0;
    oth_req  = own_id ? req0 : req1;
    hold     = own_vld & own_req & ((cnt < LIM) | ~oth_req);
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    if (hold) begin
      gnt0 = ~own_id;
      gnt1 = own_id;
    end else if (req0 & ~req1) begin
      gnt0 = 1'b1;
    end else if (req1 & ~req0) begin
      gnt1 = 1'b1;
    end else if (req0 & req1) begin
      gnt0 = ~ptr;
      gnt1 = ptr;
    end
  end

  always_comb begin
    acc      = gnt0 | gnt1;
    acc_id   = gnt1;
    acc_lock = gnt1 ? lock1 : lock0;
    acc_w    = gnt1 ? w1 : w0;
    acc_j    = gnt1 ? j1 : j0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      W          <= '0;
      J          <= '0;
      rsp_cost   <= '0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      ptr        <= 1'b0;
      own_vld    <= 1'b0;
      own_id     <= 1'b0;
      cnt        <= '0;
      pend_vld   <= 1'b0;
      pend_tag   <= 1'b0;
    end else begin
      rsp_valid0 <= pend_vld & ~pend_tag;
      rsp_valid1 <= pend_vld & pend_tag;
      if (pend_vld)
        rsp_cost <= Cost;
      if (acc) begin
        W        <= acc_w;
        J        <= acc_j;
        pend_vld <= 1'b1;
        pend_tag <= acc_id;
        ptr      <= ~acc_id;
        if (acc_lock) begin
          own_vld <= 1'b1;
          own_id  <= acc_id;
          // saturate: once at the limit only an idle peer keeps the grant here
          if (own_vld && own_id == acc_id)
            cnt <= (cnt < LIM) ? cnt + 4'd1 : cnt;
          else
            cnt <= 4'd1;
        end else begin
          own_vld <= 1'b0;
          cnt     <= '0;
        end
      end else begin
        pend_vld <= 1'b0;
        if (own_vld & ~(own_req & own_lock)) begin
          own_vld <= 1'b0;
          cnt     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cost_table_arbiter.sv
// Scoreboard bench for cost_table_arbiter; a second instance with
// MAX_LOCK=3 covers the short lock limit.
module tb_cost_table_arbiter;

  localparam int IW = 3;
  localparam int CW = 7;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req0, req1, lock0, lock1;
  logic [IW-1:0] w0, w1, j0, j1;
  logic          gnt0, gnt1, rsp_valid0, rsp_valid1;
  logic [CW-1:0] rsp_cost, Cost;
  logic [IW-1:0] W, J;

  logic          g0_3, g1_3, rv0_3, rv1_3;
  logic [CW-1:0] rc_3, Cost3;
  logic [IW-1:0] W3, J3;

  logic [CW-1:0] tbl [64];

  typedef struct {
    bit            tag;
    logic [CW-1:0] cost;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            n_run  = 0;
  int            n_fail = 0;
  int            cyc    = 0;
  logic [IW-1:0] ew, ej;
  logic [CW-1:0] last_cost;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  assign Cost  = tbl[{W, J}];
  assign Cost3 = tbl[{W3, J3}];

  cost_table_arbiter #(.IDX_W(IW), .COST_W(CW), .MAX_LOCK(8)) u_dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .w0(w0), .w1(w1), .j0(j0), .j1(j1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_cost(rsp_cost), .W(W), .J(J), .Cost(Cost)
  );

  cost_table_arbiter #(.IDX_W(IW), .COST_W(CW), .MAX_LOCK(3)) u_dut3 (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .w0(w0), .w1(w1), .j0(j0), .j1(j1),
    .gnt0(g0_3), .gnt1(g1_3),
    .rsp_valid0(rv0_3), .rsp_valid1(rv1_3),
    .rsp_cost(rc_3), .W(W3), .J(J3), .Cost(Cost3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d exp %0d", tag, cyc, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("rsp_valid0", 32'(rsp_valid0), 32'(e.tag == 1'b0));
      chk("rsp_valid1", 32'(rsp_valid1), 32'(e.tag == 1'b1));
      chk("rsp_cost", 32'(rsp_cost), 32'(e.cost));
      last_cost = e.cost;
    end else begin
      chk("idle_rv0", 32'(rsp_valid0), 0);
      chk("idle_rv1", 32'(rsp_valid1), 0);
      chk("cost_hold", 32'(rsp_cost), 32'(last_cost));
    end
  end

  // g3: -1 unchecked, 0 none, 1 gnt0, 2 gnt1 on the MAX_LOCK=3 instance
  task automatic step(input bit e0, input bit e1, input int g3 = -1);
    @(negedge CLK);
    chk("gnt0", 32'(gnt0), 32'(e0));
    chk("gnt1", 32'(gnt1), 32'(e1));
    if (g3 >= 0)
      chk("gnt_l3", 32'({g1_3, g0_3}), 32'(g3));
    chk("W", 32'(W), 32'(ew));
    chk("J", 32'(J), 32'(ej));
    if (e0) begin
      sb.push_back('{tag: 1'b0, cost: tbl[{w0, j0}], due: cyc + 2});
      ew = w0;
      ej = j0;
    end
    if (e1) begin
      sb.push_back('{tag: 1'b1, cost: tbl[{w1, j1}], due: cyc + 2});
      ew = w1;
      ej = j1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    sb.delete();
    ew        = '0;
    ej        = '0;
    last_cost = '0;
    #2;
    chk("rst_W", 32'(W), 0);
    chk("rst_J", 32'(J), 0);
    chk("rst_cost", 32'(rsp_cost), 0);
    chk("rst_rv", 32'({rsp_valid1, rsp_valid0}), 0);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    req0  = 1'b0;
    req1  = 1'b0;
    lock0 = 1'b0;
    lock1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++)
      tbl[i] = CW'((i * 37 + 11) % 128);
    tbl[{3'd2, 3'd5}] = 7'd37;
    RST = 1'b0;
    idle_inputs();
    w0 = '0; j0 = '0; w1 = '0; j1 = '0;
    ew = '0; ej = '0; last_cost = '0;
    #1;
    do_reset();

    // single lookup
    req0 = 1'b1; w0 = 3'd2; j0 = 3'd5;
    step(1'b1, 1'b0);
    req0 = 1'b0;
    step(1'b0, 1'b0);
    chk("single_cost", 32'(rsp_cost), 37);
    step(1'b0, 1'b0);

    // round robin
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    w0 = 3'd1; j0 = 3'd2; w1 = 3'd4; j1 = 3'd6;
    for (int i = 0; i < 6; i++) begin
      step(i % 2 == 0, i % 2 == 1);
      if (i % 2 == 0) begin
        w0 = w0 + 3'd1; j0 = j0 + 3'd3;
      end else begin
        w1 = w1 + 3'd2; j1 = j1 - 3'd1;
      end
    end
    idle_inputs();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // locked burst of eight, then forced release
    do_reset();
    req1 = 1'b1; w1 = 3'd5; j1 = 3'd3;
    req0 = 1'b1; lock0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w0 = IW'(i);
      j0 = IW'((i * 3) % 8);
      step(1'b1, 1'b0);
    end
    step(1'b0, 1'b1);
    idle_inputs();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // lock limit with contention on both instances
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1;
    w1 = 3'd7; j1 = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w0 = IW'(7 - i);
      j0 = IW'(i);
      step(1'b1, 1'b0, (i % 4 == 3) ? 2 : 1);
    end
    req1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w0 = IW'(i);
      step(1'b1, 1'b0, 1);
    end
    idle_inputs();
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0);

    // reset right after an accept edge
    do_reset();
    req0 = 1'b1; w0 = 3'd3; j0 = 3'd4;
    step(1'b1, 1'b0);
    idle_inputs();
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    w0 = 3'd1; j0 = 3'd1; w1 = 3'd2; j1 = 3'd2;
    step(1'b1, 1'b0);

    // idle hold
    req0 = 1'b0; req1 = 1'b1; w1 = 3'd6; j1 = 3'd1;
    step(1'b0, 1'b1);
    req1 = 1'b0;
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0);
    chk("hold_W", 32'(W), 6);
    chk("hold_J", 32'(J), 1);
    chk("hold_cost", 32'(rsp_cost), 32'(tbl[{3'd6, 3'd1}]));
    chk("sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
